// File: rtl/paddle_input.sv
// -----------------------------------------------------------------------------
// paddle_input
//
// Turns one player's two raw paddle buttons into single-cycle move pulses for
// the paddle position register. That register steps once per clock while its
// up/down input is high, so this block only ever emits one-cycle pulses and
// never levels.
//
// Each button is synchronised (two flops) and then debounced. A small move
// state machine pulses once on press. With auto-repeat enabled it then keeps
// pulsing while the button is held: the first repeat comes REPEAT_DELAY
// cycles after the first pulse, and later repeats are REPEAT_PERIOD apart.
//
// Configuration macro:
//   PADDLE_AUTOREPEAT_EN  defined   -> press pulse plus auto-repeat
//                         undefined -> exactly one pulse per debounced press;
//                                      the REPEAT state and repeat counter are
//                                      not built
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles the synchronised input must differ from the
//                    debounced level before that level flips
//   REPEAT_DELAY     cycles from the first pulse to the first repeat
//   REPEAT_PERIOD    cycles between later repeats
//   CNT_W            counter width; must hold the largest of the three counts
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   btn_up_in    in   raw up button (asynchronous, active-high)
//   btn_down_in  in   raw down button (asynchronous, active-high)
//   up           out  one-cycle move-up pulse (registered)
//   down         out  one-cycle move-down pulse (registered)
//   up_held      out  debounced up level (registered)
//   down_held    out  debounced down level (registered)
// -----------------------------------------------------------------------------
module paddle_input #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up_in,
    input  logic btn_down_in,
    output logic up,
    output logic down,
    output logic up_held,
    output logic down_held
);

    // Move state machine encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
`ifdef PADDLE_AUTOREPEAT_EN
    localparam logic [1:0] REPEAT = 2'd2;
`endif

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef PADDLE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]       raw;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       held;
    logic [CNT_W-1:0] db_cnt [2];

    assign raw = {btn_down_in, btn_up_in};

    // -------------------------------------------------------------------------
    // Synchroniser and debounce. The counter only runs while the synchronised
    // input disagrees with the debounced level; any agreement clears it, so a
    // glitch shorter than DEBOUNCE_CYCLES cycles never flips the level.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 2'b00;
            s2   <= 2'b00;
            held <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == held[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    held[i]   <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign up_held   = held[0];
    assign down_held = held[1];

    // -------------------------------------------------------------------------
    // Move state machine. dir: 0 = up, 1 = down.
    // A move in progress aborts when its own button is released or the other
    // button becomes held; with both held IDLE issues nothing, and releasing
    // one of them lets IDLE start a fresh press in the remaining direction.
    // -------------------------------------------------------------------------
    logic [1:0] state;
    logic       dir;
    logic       abort;

`ifdef PADDLE_AUTOREPEAT_EN
    logic [CNT_W-1:0] rc;
`endif

    assign abort = dir ? (!held[1] || held[0]) : (!held[0] || held[1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            dir   <= 1'b0;
            up    <= 1'b0;
            down  <= 1'b0;
`ifdef PADDLE_AUTOREPEAT_EN
            rc    <= '0;
`endif
        end else begin
            // Pulses are one cycle wide unless re-asserted below.
            up   <= 1'b0;
            down <= 1'b0;
            case (state)
                IDLE: begin
                    if (held[0] ^ held[1]) begin
                        dir   <= held[1];
                        up    <= held[0];
                        down  <= held[1];
                        state <= DELAY;
`ifdef PADDLE_AUTOREPEAT_EN
                        rc    <= '0;
`endif
                    end
                end
                DELAY: begin
                    if (abort) begin
                        state <= IDLE;
`ifdef PADDLE_AUTOREPEAT_EN
                        rc    <= '0;
                    end else if (rc == RD_LAST) begin
                        up    <= ~dir;
                        down  <= dir;
                        rc    <= '0;
                        state <= REPEAT;
                    end else begin
                        rc    <= rc + 1'b1;
`endif
                    end
                end
`ifdef PADDLE_AUTOREPEAT_EN
                REPEAT: begin
                    if (abort) begin
                        state <= IDLE;
                        rc    <= '0;
                    end else if (rc == RP_LAST) begin
                        up    <= ~dir;
                        down  <= dir;
                        rc    <= '0;
                    end else begin
                        rc    <= rc + 1'b1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/paddle_input.md
# paddle_input

Conditions the two raw paddle push-buttons of one player into clean move commands for the paddle position register. Each button is synchronised and debounced. A small state machine then emits single-cycle `up`/`down` move pulses: one on press, then auto-repeat while the button is held. The paddle register moves one step per clock its `up`/`down` input is high, so this block must deliver pulses, never levels.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles a synchronised input must differ from its debounced level before that level flips (10 ms at 50 MHz).
- `REPEAT_DELAY`, default 12500000: cycles from the first move pulse to the first repeat pulse.
- `REPEAT_PERIOD`, default 2500000: cycles between subsequent repeat pulses.
- `CNT_W`, default 24: width of the debounce and repeat counters; must hold the largest of the three counts.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `btn_up_in` in 1: raw up button, asynchronous, active-high.
- `btn_down_in` in 1: raw down button, asynchronous, active-high.
- `up` out 1: one-cycle move-up pulse, registered.
- `down` out 1: one-cycle move-down pulse, registered.
- `up_held` out 1: debounced up level, registered.
- `down_held` out 1: debounced down level, registered.

## Operation
- **Synchroniser**: each button passes through a 2-flop synchroniser (`s1`, `s2`).
- **Debounce**: one debounce counter per button.
  - If `s2` equals the held level, the counter clears.
  - Otherwise the counter increments. On the edge where it reaches `DEBOUNCE_CYCLES-1`, the held level takes the value of `s2` and the counter clears.
  - Glitches shorter than `DEBOUNCE_CYCLES` cycles never reach the held level.
- **Move state machine**: states IDLE, DELAY, REPEAT. The machine holds a latched direction `dir` and a repeat counter `rc`.
  - *IDLE*: if exactly one of `up_held`/`down_held` is 1, pulse that direction, latch `dir`, clear `rc`, go to DELAY. If neither or both are 1, stay in IDLE with no pulse.
  - *Abort (DELAY or REPEAT)*: if the held level for `dir` drops, or the opposite held level rises, go to IDLE with no pulse and clear `rc`.
  - *DELAY, no abort*: increment `rc`. At `REPEAT_DELAY-1`, pulse `dir`, clear `rc`, go to REPEAT.
  - *REPEAT, no abort*: increment `rc`. At `REPEAT_PERIOD-1`, pulse `dir` and clear `rc`.
- **Simultaneous buttons**: `up` and `down` are never high in the same cycle. When both buttons are held, no pulses are issued. When one of the two is then released, IDLE sees a single held button and issues a fresh first pulse in that direction.
- **Counter arithmetic**: unsigned, `CNT_W` bits. Counters never wrap, because each one clears at its terminal count.

## Timing
- **Reset values**: `up`=0, `down`=0, `up_held`=0, `down_held`=0. Synchroniser flops, debounce counters and `rc` are 0, and the state is IDLE.
- **Reset mid-hold**: after `reset` deasserts with a button still pressed, the full debounce latency applies again, followed by a fresh first pulse. No pulse is emitted during reset.
- **Latency**: number the first edge that samples the new raw level as edge 0.
  - `s2` changes after edge 1.
  - The held level flips after edge `DEBOUNCE_CYCLES+1`.
  - The first pulse is high during the cycle after edge `DEBOUNCE_CYCLES+2`.
- **Repeat spacing**: the first repeat pulse comes `REPEAT_DELAY` cycles after the first pulse. Later pulses are spaced `REPEAT_PERIOD` cycles apart.
- **Release**: the first edge where the held level is seen low stops pulsing. No pulse is issued on release.

## Configuration
- **`PADDLE_AUTOREPEAT_EN` defined**: auto-repeat behaves as described above.
- **`PADDLE_AUTOREPEAT_EN` undefined**:
  - DELAY never advances; `rc` is held at 0 and the REPEAT state is not implemented.
  - Exactly one pulse is issued per debounced press.
  - The abort rules still apply.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `PADDLE_AUTOREPEAT_EN` defined unless stated.
- **Reset**: hold `reset` 3 cycles with `btn_up_in`=1 -> all outputs 0 throughout. After release, `up_held` rises after edge 5 and the `up` pulse follows after edge 6.
- **Press and hold**: raise `btn_up_in` at edge 0 and hold 30 cycles -> `up` is 1 for exactly one cycle after each of edges 6, 16, 19, 22, 25 and 28. `down` stays 0.
- **Bounce**: toggle `btn_down_in` every 2 cycles for 20 cycles, then hold it at 0 -> `down_held` and `down` stay 0.
- **Both buttons**: hold up, then press down for 15 cycles, then release down -> no pulses while both are held. One `up` pulse occurs once `down_held` falls, followed by a new 10-cycle delay.
- **Short press**: press up for 8 cycles -> exactly one `up` pulse. No pulse on release.
- **Auto-repeat compiled out**: with `PADDLE_AUTOREPEAT_EN` undefined, hold up for 40 cycles -> exactly one `up` pulse, after edge 6.
